dual_debounce: RTL and testbench

- Input conditioning stage that sits directly upstream of the two-input OR control block.
- Takes two raw, asynchronous switch/level inputs and synchronises them into the clock domain.
- Debounces each input independently and drives clean levels onto the OR block's a and b inputs.
- Also emits single-cycle rise pulses so downstream logic can count presses.

---
 rtl/dual_debounce.sv | 188 ++++++++++++++++++
 tb/tb_dual_debounce.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dual_debounce.sv
// -----------------------------------------------------------------------------
// dual_debounce
//
// Input conditioning stage for the two-input OR control block. Two raw,
// asynchronous switch/level inputs are synchronised into the clk domain. Each
// one is then debounced on its own and presented as a clean level, together
// with a one-cycle rise pulse that downstream logic can use to count presses.
//
// Ports:
//   clk     in   single clock, all state changes on the rising edge
//   rst_n   in   asynchronous, active-low reset
//   a_raw   in   raw asynchronous input, channel A
//   b_raw   in   raw asynchronous input, channel B
//   a_o     out  debounced level, channel A (drives OR block input a)
//   b_o     out  debounced level, channel B (drives OR block input b)
//   a_rise  out  one-cycle pulse when a_o goes 0->1
//   b_rise  out  one-cycle pulse when b_o goes 0->1
//   a_fall  out  one-cycle pulse when a_o goes 1->0 (optional)
//   b_fall  out  one-cycle pulse when b_o goes 1->0 (optional)
//
// Parameters:
//   DEBOUNCE_CYCLES  consecutive synchronised-stable cycles needed before a
//                    new level is accepted (legal range 2..65535)
//
// Optional feature macro:
//   DEBOUNCE_FALL_PULSE_EN  when defined, adds the a_fall/b_fall ports and
//                           their pulse registers. The level FSM and the rise
//                           pulses behave identically either way.
// -----------------------------------------------------------------------------
module dual_debounce #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic a_raw,
    input  logic b_raw,
    output logic a_o,
    output logic b_o,
    output logic a_rise,
    output logic b_rise
`ifdef DEBOUNCE_FALL_PULSE_EN
    ,
    output logic a_fall,
    output logic b_fall
`endif
);

    // One spare bit above what DEBOUNCE_CYCLES needs, so the terminal count
    // always fits comfortably and the counter can never wrap.
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES) + 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        S_LOW,
        S_WAIT_HIGH,
        S_HIGH,
        S_WAIT_LOW
    } state_t;

    // Channel 0 is A, channel 1 is B; the two channels share nothing but clk
    // and rst_n.
    logic [1:0] rawIn;
    logic [1:0] levelOut;
    logic [1:0] riseOut;

    assign rawIn = {b_raw, a_raw};

`ifdef DEBOUNCE_FALL_PULSE_EN
    logic [1:0] fallOut;
`endif

    for (genvar ch = 0; ch < 2; ch++) begin : g_chan

        logic             syncMeta_q;
        logic             syncOut_q;
        state_t           state_q;
        logic [CNT_W-1:0] count_q;
        logic             level_q;
        logic             rise_q;
`ifdef DEBOUNCE_FALL_PULSE_EN
        logic             fall_q;
`endif

        // Synchroniser and debounce FSM for one channel. The second
        // synchroniser flop (syncOut_q) is the only view of the raw input the
        // FSM ever gets, so metastability stays confined to syncMeta_q.
        //
        // The counter starts at 1 on leaving a stable state, because the
        // sample that triggered the departure already counts as the first
        // stable cycle; reaching CNT_LAST therefore means DEBOUNCE_CYCLES
        // consecutive samples at the new level. Any sample back at the old
        // level returns to the stable state and clears the count, which is
        // also how an input toggling every cycle ends up holding its last
        // accepted level.
        //
        // Level and pulses are registered here so that they change on the
        // very edge that makes the state transition.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                syncMeta_q <= 1'b0;
                syncOut_q  <= 1'b0;
                state_q    <= S_LOW;
                count_q    <= '0;
                level_q    <= 1'b0;
                rise_q     <= 1'b0;
`ifdef DEBOUNCE_FALL_PULSE_EN
                fall_q     <= 1'b0;
`endif
            end else begin
                syncMeta_q <= rawIn[ch];
                syncOut_q  <= syncMeta_q;
                rise_q     <= 1'b0;
`ifdef DEBOUNCE_FALL_PULSE_EN
                fall_q     <= 1'b0;
`endif
                case (state_q)
                    S_LOW: begin
                        if (syncOut_q) begin
                            state_q <= S_WAIT_HIGH;
                            count_q <= CNT_ONE;
                        end
                    end

                    S_WAIT_HIGH: begin
                        if (!syncOut_q) begin
                            state_q <= S_LOW;
                            count_q <= '0;
                        end else if (count_q == CNT_LAST) begin
                            state_q <= S_HIGH;
                            count_q <= '0;
                            level_q <= 1'b1;
                            rise_q  <= 1'b1;
                        end else begin
                            count_q <= count_q + CNT_ONE;
                        end
                    end

                    S_HIGH: begin
                        if (!syncOut_q) begin
                            state_q <= S_WAIT_LOW;
                            count_q <= CNT_ONE;
                        end
                    end

                    S_WAIT_LOW: begin
                        if (syncOut_q) begin
                            state_q <= S_HIGH;
                            count_q <= '0;
                        end else if (count_q == CNT_LAST) begin
                            state_q <= S_LOW;
                            count_q <= '0;
                            level_q <= 1'b0;
`ifdef DEBOUNCE_FALL_PULSE_EN
                            fall_q  <= 1'b1;
`endif
                        end else begin
                            count_q <= count_q + CNT_ONE;
                        end
                    end

                    default: begin
                        state_q <= S_LOW;
                        count_q <= '0;
                        level_q <= 1'b0;
                    end
                endcase
            end
        end

        assign levelOut[ch] = level_q;
        assign riseOut[ch]  = rise_q;
`ifdef DEBOUNCE_FALL_PULSE_EN
        assign fallOut[ch]  = fall_q;
`endif
    end

    assign a_o    = levelOut[0];
    assign b_o    = levelOut[1];
    assign a_rise = riseOut[0];
    assign b_rise = riseOut[1];
`ifdef DEBOUNCE_FALL_PULSE_EN
    assign a_fall = fallOut[0];
    assign b_fall = fallOut[1];
`endif

endmodule

// File: tb/tb_dual_debounce.sv
// -----------------------------------------------------------------------------
// tb_dual_debounce
//
// Self-checking bench for dual_debounce. Every clock cycle the bench drives
// both raw inputs, advances a small behavioural model on the rising edge and
// queues the outputs it expects; on the following falling edge it pops that
// entry and compares it against the DUT. The model describes the debouncer as
// "flip the level once the synchronised input has disagreed with it for
// DEBOUNCE_CYCLES consecutive samples", with the synchroniser modelled as a
// two-sample delay of the raw inputs.
// -----------------------------------------------------------------------------
module tb_dual_debounce;

    localparam int N = 4;

    logic clk;
    logic rst_n;
    logic a_raw;
    logic b_raw;
    logic a_o;
    logic b_o;
    logic a_rise;
    logic b_rise;
    logic [1:0] obsFall;

`ifdef DEBOUNCE_FALL_PULSE_EN
    localparam bit FALL_EN = 1'b1;
    logic a_fall;
    logic b_fall;
    assign obsFall = {a_fall, b_fall};
`else
    localparam bit FALL_EN = 1'b0;
    assign obsFall = 2'b00;
`endif

    dual_debounce #(
        .DEBOUNCE_CYCLES(N)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .a_raw  (a_raw),
        .b_raw  (b_raw),
        .a_o    (a_o),
        .b_o    (b_o),
        .a_rise (a_rise),
        .b_rise (b_rise)
`ifdef DEBOUNCE_FALL_PULSE_EN
        ,
        .a_fall (a_fall),
        .b_fall (b_fall)
`endif
    );

    // Observed outputs packed as {a_o, b_o, a_rise, b_rise, a_fall, b_fall}.
    logic [5:0] obsVec;
    assign obsVec = {a_o, b_o, a_rise, b_rise, obsFall};

    // Free-running 100 MHz clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         compared   = 0;
    int         mismatched = 0;
    string      phase      = "init";
    logic [5:0] expQ[$];

    logic [1:0] mSync1;
    logic [1:0] mSync2;
    logic [1:0] mLevel;
    logic [1:0] mRise;
    logic [1:0] mFall;
    int         mRun [2];

    int cycle        = 0;
    int riseCntA     = 0;
    int riseCntB     = 0;
    int lastRiseCycA = -1;
    int lastRiseCycB = -1;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h (t=%0t)",
                     tag, observed, expected, $time);
        end
    endtask

    task automatic modelClear();
        mSync1 = 2'b00;
        mSync2 = 2'b00;
        mLevel = 2'b00;
        mRise  = 2'b00;
        mFall  = 2'b00;
        mRun[0] = 0;
        mRun[1] = 0;
    endtask

    // Advance the model by one rising edge and queue the expected outputs.
    task automatic modelStep();
        logic [1:0] sNow;
        logic [1:0] expFall;
        if (!rst_n) begin
            modelClear();
        end else begin
            sNow   = mSync2;
            mSync2 = mSync1;
            mSync1 = {b_raw, a_raw};
            mRise  = 2'b00;
            mFall  = 2'b00;
            for (int ch = 0; ch < 2; ch++) begin
                if (sNow[ch] != mLevel[ch]) begin
                    mRun[ch]++;
                    if (mRun[ch] == N) begin
                        mLevel[ch] = sNow[ch];
                        mRun[ch]   = 0;
                        if (sNow[ch]) mRise[ch] = 1'b1;
                        else          mFall[ch] = 1'b1;
                    end
                end else begin
                    mRun[ch] = 0;
                end
            end
        end
        expFall = FALL_EN ? {mFall[0], mFall[1]} : 2'b00;
        expQ.push_back({mLevel[0], mLevel[1], mRise[0], mRise[1], expFall});
    endtask

    // Drive one cycle of stimulus, then compare on the falling edge.
    task automatic applyStimulus(input logic a, input logic b);
        logic [5:0] expected;
        a_raw = a;
        b_raw = b;
        @(posedge clk);
        modelStep();
        cycle++;
        @(negedge clk);
        expected = expQ.pop_front();
        checkOutput({phase, "/outputs"}, {26'd0, obsVec}, {26'd0, expected});
        if (a_rise) begin
            riseCntA++;
            lastRiseCycA = cycle;
        end
        if (b_rise) begin
            riseCntB++;
            lastRiseCycB = cycle;
        end
    endtask

    initial begin
        int lat;
        int baseA;
        int baseB;
        logic aVal;
        logic bVal;

        rst_n = 1'b0;
        a_raw = 1'b0;
        b_raw = 1'b0;
        modelClear();

        // Reset state, then idle.
        phase = "reset";
        #1;
        checkOutput("reset/initial", {26'd0, obsVec}, 32'd0);
        @(negedge clk);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0);
        rst_n = 1'b1;
        phase = "idle";
        for (int i = 0; i < 20; i++) applyStimulus(1'b0, 1'b0);

        // Clean press on A, then clean release.
        phase = "press";
        baseA = riseCntA;
        lat = -1;
        for (int i = 0; i < 12; i++) begin
            applyStimulus(1'b1, 1'b0);
            if (a_o && lat < 0) lat = i;
        end
        checkOutput("press/latency", 32'(lat), 32'(N + 1));
        checkOutput("press/riseCount", 32'(riseCntA - baseA), 32'd1);
        phase = "release";
        lat = -1;
        for (int i = 0; i < 12; i++) begin
            applyStimulus(1'b0, 1'b0);
            if (!a_o && lat < 0) lat = i;
        end
        checkOutput("release/latency", 32'(lat), 32'(N + 1));

        // Glitch shorter than the debounce window is rejected.
        phase = "glitch3";
        baseA = riseCntA;
        for (int i = 0; i < N - 1; i++) applyStimulus(1'b1, 1'b0);
        for (int i = 0; i < 12; i++) applyStimulus(1'b0, 1'b0);
        checkOutput("glitch3/riseCount", 32'(riseCntA - baseA), 32'd0);

        // A pulse exactly as long as the window is accepted.
        phase = "glitch4";
        baseA = riseCntA;
        for (int i = 0; i < N; i++) applyStimulus(1'b1, 1'b0);
        for (int i = 0; i < 12; i++) applyStimulus(1'b0, 1'b0);
        checkOutput("glitch4/riseCount", 32'(riseCntA - baseA), 32'd1);

        // Both channels rise together.
        phase = "simultaneous";
        baseA = riseCntA;
        baseB = riseCntB;
        for (int i = 0; i < 10; i++) applyStimulus(1'b1, 1'b1);
        checkOutput("simul/riseCountA", 32'(riseCntA - baseA), 32'd1);
        checkOutput("simul/riseCountB", 32'(riseCntB - baseB), 32'd1);
        checkOutput("simul/sameCycle", 32'(lastRiseCycA), 32'(lastRiseCycB));
        checkOutput("simul/orX", {31'd0, a_o | b_o}, 32'd1);
        for (int i = 0; i < 12; i++) applyStimulus(1'b0, 1'b0);

        // Reset while A is still qualifying: count discarded, re-qualify.
        phase = "resetWait";
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0);
        #2 rst_n = 1'b0;
        #1 checkOutput("resetWait/async", {26'd0, obsVec}, 32'd0);
        modelClear();
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0);
        rst_n = 1'b1;
        lat = -1;
        for (int i = 0; i < 12; i++) begin
            applyStimulus(1'b1, 1'b0);
            if (a_o && lat < 0) lat = i;
        end
        checkOutput("resetWait/latency", 32'(lat), 32'(N + 1));

        // Reset while A is accepted high must clear a_o immediately.
        phase = "resetHigh";
        #2 rst_n = 1'b0;
        #1 checkOutput("resetHigh/async", {26'd0, obsVec}, 32'd0);
        modelClear();
        for (int i = 0; i < 2; i++) applyStimulus(1'b0, 1'b0);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) applyStimulus(1'b0, 1'b0);

        // Inputs toggling every cycle hold their last accepted level.
        phase = "toggleLow";
        for (int i = 0; i < 20; i++) applyStimulus(1'(i % 2), 1'b0);
        phase = "toggleHigh";
        for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b1);
        for (int i = 0; i < 20; i++) applyStimulus(1'b0, 1'(i % 2));
        checkOutput("toggleHigh/bHeld", {31'd0, b_o}, 32'd1);
        for (int i = 0; i < 12; i++) applyStimulus(1'b0, 1'b0);

        // Random bursty traffic on both channels.
        phase = "random";
        aVal = 1'b0;
        bVal = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 4) == 0) aVal = ~aVal;
            if ($urandom_range(0, 4) == 0) bVal = ~bVal;
            applyStimulus(aVal, bVal);
        end

        checkOutput("scoreboard/drain", 32'(expQ.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
